param_loader: RTL and testbench
===============================

PARAM_LOADER -- requirements
Module: param_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 16, memory and write-data width.
REQ-002 SHALL have parameter ADDR_W, default 14, memory address width.
REQ-003 SHALL have parameters LEN0..LEN4, defaults 150, 2400, 12800, 4096, 320, word counts for regions 0..4 (conv1, conv2, conv3, fc1, fc2).
REQ-004 SHALL have parameters BASE0..BASE4, defaults 0, 150, 2550, 15350, 19446 (truncated to ADDR_W), region start addresses.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 conv_weight1, conv_weight2, conv_weight3, fc_weight1, fc_weight2  in  1 each  level load requests for regions 0..4.
REQ-008 mem_rd_en  out  1  read strobe to parameter memory.
REQ-009 mem_addr  out  ADDR_W  read address.
REQ-010 mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en.
REQ-011 wr_en  out  1  destination write strobe.
REQ-012 wr_sel  out  3  region id (0..4) of current write.
REQ-013 wr_addr  out  ADDR_W  word offset within region (0..LENn-1).
REQ-014 wr_data  out  DATA_W  write data.
REQ-015 done_conv_weight1, done_conv_weight2, done_conv_weight3, done_fc_weight1, done_fc_weight2  out  1 each  one-cycle completion pulses.
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement states IDLE, READ, DRAIN, DONE, RELEASE.
REQ-018 IDLE: if any request high, SHALL latch region id (lowest index wins when several high), clear counter, go READ.
REQ-019 READ: SHALL assert mem_rd_en with mem_addr = BASEn + cnt, increment cnt each cycle; after issuing cnt = LENn-1 go DRAIN.
REQ-020 wr_en, wr_sel, wr_addr SHALL be mem_rd_en, region id, cnt delayed by one register; wr_data SHALL be mem_rdata combinationally.
REQ-021 DRAIN: SHALL issue no read; the last write occurs this cycle; go DONE.
REQ-022 DONE: SHALL pulse the done output of the latched region for exactly one cycle; go RELEASE.
REQ-023 RELEASE: SHALL wait until the latched region's request is low, then go IDLE; other requests are ignored here.
REQ-024 Latency: request first sampled high at edge t -> mem_rd_en cycles t+1..t+LEN, wr_en cycles t+2..t+LEN+1, done in cycle t+LEN+2.
REQ-025 Exactly LENn writes per load, offsets 0..LENn-1 strictly increasing, no gaps.
REQ-026 If the latched request drops during READ or DRAIN, SHALL abort: no further reads, no done pulse, go IDLE next cycle; the in-flight write still completes.
REQ-027 Address arithmetic SHALL be modulo 2^ADDR_W; cnt width SHALL hold max LENn.
REQ-028 Requests changing while busy SHALL not alter the latched region.

Reset
REQ-029 reset high at an edge SHALL force IDLE, cnt=0, region id=0, and all outputs (mem_rd_en, mem_addr, wr_en, wr_sel, wr_addr, done_*, busy) to 0, wr_data excepted.
REQ-030 reset mid-load SHALL discard the load with no done pulse; after reset deasserts, a still-high request SHALL start a fresh load from offset 0.

Verification
REQ-031 LEN0=4, BASE0=10, conv_weight1 high at edge 0 -> mem_addr 10,11,12,13 cycles 1-4; wr_addr 0..3 cycles 2-5; done_conv_weight1 pulse cycle 6 only.
REQ-032 Controller-style handoff: conv_weight1 drops and conv_weight2 rises the cycle after done -> second load starts with no idle gap beyond RELEASE->IDLE, wr_sel=1.
REQ-033 conv_weight3 and fc_weight1 high together -> region 2 loaded, wr_sel=2; region 3 loads only after its own IDLE sample.
REQ-034 fc_weight2 dropped after 2 of 320 reads -> exactly 2 writes, no done_fc_weight2, busy low within 2 cycles.
REQ-035 reset at cycle 3 of a LEN0=4 load -> all outputs 0 next cycle; held request restarts at offset 0 after release.
REQ-036 Request held high after done -> no second load, done pulses once, busy stays high in RELEASE.

Source files
------------

// File: rtl/param_loader.sv
`default_nettype none
// ============================================================================
//  Module   : param_loader
//  Purpose  : Streams one of five weight regions out of a parameter memory
//             into a destination write port. A load is started by a level
//             request and completes with a one-cycle done pulse.
//  Revision : 1.0  initial release
// ============================================================================
module param_loader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 14,
    parameter int LEN0   = 150,
    parameter int LEN1   = 2400,
    parameter int LEN2   = 12800,
    parameter int LEN3   = 4096,
    parameter int LEN4   = 320,
    parameter int BASE0  = 0,
    parameter int BASE1  = 150,
    parameter int BASE2  = 2550,
    parameter int BASE3  = 15350,
    parameter int BASE4  = 19446
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              conv_weight1,
    input  logic              conv_weight2,
    input  logic              conv_weight3,
    input  logic              fc_weight1,
    input  logic              fc_weight2,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wr_en,
    output logic [2:0]        wr_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              done_conv_weight1,
    output logic              done_conv_weight2,
    output logic              done_conv_weight3,
    output logic              done_fc_weight1,
    output logic              done_fc_weight2,
    output logic              busy
);

    function automatic int f_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter must be able to represent the largest region length.
    localparam int c_LEN_MAX = f_max(f_max(f_max(LEN0, LEN1), f_max(LEN2, LEN3)), LEN4);
    localparam int c_CNT_W   = (c_LEN_MAX < 2) ? 1 : $clog2(c_LEN_MAX + 1);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_READ    = 3'd1;
    localparam logic [2:0] c_DRAIN   = 3'd2;
    localparam logic [2:0] c_DONE    = 3'd3;
    localparam logic [2:0] c_RELEASE = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         r_region;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_wr_en;
    logic [2:0]         r_wr_sel;
    logic [ADDR_W-1:0]  r_wr_addr;

    logic [4:0]         w_req;
    logic               w_any_req;
    logic [2:0]         w_first;
    logic               w_req_held;
    logic [ADDR_W-1:0]  w_base;
    logic [c_CNT_W-1:0] w_last;
    logic               w_reading;
    logic               w_done;

    assign w_req     = {fc_weight2, fc_weight1, conv_weight3, conv_weight2, conv_weight1};
    assign w_any_req = |w_req;

    // Priority pick of the lowest-numbered active request.
    always_comb begin
        w_first = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (w_req[i]) begin
                w_first = 3'(i);
            end
        end
    end

    // Per-region constants and the request that belongs to the latched region.
    always_comb begin
        w_base     = '0;
        w_last     = '0;
        w_req_held = 1'b0;
        case (r_region)
            3'd0: begin
                w_base     = ADDR_W'(BASE0);
                w_last     = c_CNT_W'(LEN0 - 1);
                w_req_held = conv_weight1;
            end
            3'd1: begin
                w_base     = ADDR_W'(BASE1);
                w_last     = c_CNT_W'(LEN1 - 1);
                w_req_held = conv_weight2;
            end
            3'd2: begin
                w_base     = ADDR_W'(BASE2);
                w_last     = c_CNT_W'(LEN2 - 1);
                w_req_held = conv_weight3;
            end
            3'd3: begin
                w_base     = ADDR_W'(BASE3);
                w_last     = c_CNT_W'(LEN3 - 1);
                w_req_held = fc_weight1;
            end
            3'd4: begin
                w_base     = ADDR_W'(BASE4);
                w_last     = c_CNT_W'(LEN4 - 1);
                w_req_held = fc_weight2;
            end
            default: begin
                w_base     = '0;
                w_last     = '0;
                w_req_held = 1'b0;
            end
        endcase
    end

    // A read is suppressed in the very cycle the owning request drops, so an
    // abort never issues a stray read.
    assign w_reading = (r_state == c_READ) && w_req_held;
    assign mem_rd_en = w_reading;
    assign mem_addr  = w_reading ? (w_base + ADDR_W'(r_cnt)) : '0;

    // Load sequencing: latch region, walk the counter, finish or abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_region <= 3'd0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_any_req) begin
                        r_region <= w_first;
                        r_cnt    <= '0;
                        r_state  <= c_READ;
                    end
                end
                c_READ: begin
                    if (!w_req_held) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                        if (r_cnt == w_last) begin
                            r_state <= c_DRAIN;
                        end
                    end
                end
                c_DRAIN: begin
                    r_state <= w_req_held ? c_DONE : c_IDLE;
                end
                c_DONE: begin
                    r_state <= c_RELEASE;
                end
                c_RELEASE: begin
                    if (!w_req_held) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Write side trails the read side by one cycle to match memory latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_en   <= 1'b0;
            r_wr_sel  <= 3'd0;
            r_wr_addr <= '0;
        end else begin
            r_wr_en   <= w_reading;
            r_wr_sel  <= r_region;
            r_wr_addr <= ADDR_W'(r_cnt);
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_sel  = r_wr_sel;
    assign wr_addr = r_wr_addr;
    assign wr_data = mem_rdata;

    assign w_done            = (r_state == c_DONE);
    assign done_conv_weight1 = w_done && (r_region == 3'd0);
    assign done_conv_weight2 = w_done && (r_region == 3'd1);
    assign done_conv_weight3 = w_done && (r_region == 3'd2);
    assign done_fc_weight1   = w_done && (r_region == 3'd3);
    assign done_fc_weight2   = w_done && (r_region == 3'd4);
    assign busy              = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_param_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_param_loader
//  Purpose  : Self-checking bench for param_loader. Expected behaviour is
//             derived from the load timeline: a load started at edge t reads
//             during t+1..t+LEN, writes one cycle behind each read, and pulses
//             done at t+LEN+2, then holds busy until its request drops.
//  Revision : 1.0  initial release
// ============================================================================
module tb_param_loader;

    localparam int AW = 14;
    localparam int DW = 16;
    localparam int L0 = 4,  L1 = 7,   L2 = 5,     L3 = 3,   L4 = 320;
    localparam int B0 = 10, B1 = 100, B2 = 16382, B3 = 200, B4 = 19446;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    req;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic          wr_en;
    logic [2:0]    wr_sel;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          d0, d1, d2, d3, d4;
    logic          busy;
    logic [4:0]    done_v;
    logic [4:0]    rnd_req;
    logic [15:0]   salt;

    assign done_v = {d4, d3, d2, d1, d0};

    param_loader #(
        .DATA_W(DW), .ADDR_W(AW),
        .LEN0(L0), .LEN1(L1), .LEN2(L2), .LEN3(L3), .LEN4(L4),
        .BASE0(B0), .BASE1(B1), .BASE2(B2), .BASE3(B3), .BASE4(B4)
    ) dut (
        .clk(clk), .reset(reset),
        .conv_weight1(req[0]), .conv_weight2(req[1]), .conv_weight3(req[2]),
        .fc_weight1(req[3]), .fc_weight2(req[4]),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .done_conv_weight1(d0), .done_conv_weight2(d1), .done_conv_weight3(d2),
        .done_fc_weight1(d3), .done_fc_weight2(d4),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] word_at(input int a);
        return DW'(a * 40503) ^ salt;
    endfunction

    // Parameter memory: one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= word_at(int'(mem_addr));
    end

    function automatic int len_of(input int r);
        case (r)
            0: return L0;
            1: return L1;
            2: return L2;
            3: return L3;
            default: return L4;
        endcase
    endfunction

    function automatic int base_of(input int r);
        case (r)
            0: return B0;
            1: return B1;
            2: return B2;
            3: return B3;
            default: return B4;
        endcase
    endfunction

    function automatic int lowest(input logic [4:0] r);
        for (int i = 0; i < 5; i++) if (r[i]) return i;
        return 0;
    endfunction

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference model: where the current load sits on its timeline.
    bit m_busy = 1'b0;
    bit m_prev_rd = 1'b0;
    bit m_after_reset = 1'b0;
    int m_k = 0;
    int m_reg = 0;
    int m_prev_off = 0;
    int m_prev_reg = 0;
    int m_prev_addr = 0;
    int wr_seen = 0;

    function automatic bit exp_reading();
        return m_busy && (m_k >= 1) && (m_k <= len_of(m_reg)) && req[m_reg];
    endfunction

    task automatic check_outputs();
        bit erd;
        int len;
        erd = exp_reading();
        len = len_of(m_reg);
        chk("busy", 32'(busy), 32'(m_busy));
        chk("mem_rd_en", 32'(mem_rd_en), 32'(erd));
        if (erd) chk("mem_addr", 32'(mem_addr), (base_of(m_reg) + m_k - 1) % (1 << AW));
        chk("wr_en", 32'(wr_en), 32'(m_prev_rd));
        if (m_prev_rd) begin
            chk("wr_sel", 32'(wr_sel), m_prev_reg);
            chk("wr_addr", 32'(wr_addr), m_prev_off);
            chk("wr_data", 32'(wr_data), 32'(word_at(m_prev_addr)));
        end
        for (int r = 0; r < 5; r++) begin
            chk($sformatf("done%0d", r), 32'(done_v[r]),
                32'(m_busy && (m_k == len + 2) && (r == m_reg)));
        end
        if (wr_en === 1'b1) wr_seen++;
        if (m_busy && (m_k == len + 2)) chk("write_count", wr_seen, len);
        if (m_after_reset) begin
            chk("rst_mem_addr", 32'(mem_addr), 0);
            chk("rst_wr_sel", 32'(wr_sel), 0);
            chk("rst_wr_addr", 32'(wr_addr), 0);
        end
    endtask

    task automatic model_edge();
        bit erd;
        int len;
        erd = exp_reading();
        len = len_of(m_reg);
        m_after_reset = 1'b0;
        if (reset) begin
            m_busy        = 1'b0;
            m_prev_rd     = 1'b0;
            m_after_reset = 1'b1;
        end else begin
            m_prev_rd   = erd;
            m_prev_off  = m_k - 1;
            m_prev_reg  = m_reg;
            m_prev_addr = (base_of(m_reg) + m_k - 1) % (1 << AW);
            if (!m_busy) begin
                if (req != 5'd0) begin
                    m_reg   = lowest(req);
                    m_k     = 1;
                    m_busy  = 1'b1;
                    wr_seen = 0;
                end
            end else if (m_k <= len + 1) begin
                if (!req[m_reg]) m_busy = 1'b0;
                else m_k++;
            end else if (m_k == len + 2) begin
                m_k++;
            end else if (!req[m_reg]) begin
                m_busy = 1'b0;
            end
        end
    endtask

    // One clock cycle: drive inputs, check mid-cycle, advance model at the edge.
    task automatic step(input logic [4:0] r, input logic rst);
        req   = r;
        reset = rst;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        salt    = 16'($urandom);
        rnd_req = 5'd0;
        reset   = 1'b1;
        req     = 5'd0;
        @(posedge clk);
        #1;
        m_after_reset = 1'b1;
        step(5'd0, 1'b1);
        step(5'd0, 1'b0);

        // Region 0 load, then controller-style handoff to region 1.
        repeat (L0 + 3) step(5'b00001, 1'b0);
        step(5'b00010, 1'b0);
        repeat (L1 + 3) step(5'b00010, 1'b0);
        step(5'b00000, 1'b0);
        step(5'b00000, 1'b0);

        // Simultaneous requests: region 2 wins (address wraps), region 3 follows.
        repeat (L2 + 3) step(5'b01100, 1'b0);
        step(5'b01000, 1'b0);
        repeat (L3 + 3) step(5'b01000, 1'b0);
        step(5'b00000, 1'b0);
        step(5'b00000, 1'b0);

        // Abort of a long region after two reads.
        repeat (3) step(5'b10000, 1'b0);
        repeat (3) step(5'b00000, 1'b0);
        chk("abort_writes", wr_seen, 2);
        chk("abort_busy", 32'(busy), 0);

        // Reset in the middle of a load, request held through it.
        repeat (3) step(5'b00001, 1'b0);
        step(5'b00001, 1'b1);
        repeat (L0 + 3) step(5'b00001, 1'b0);

        // Request held after done: stays in release without reloading.
        repeat (6) step(5'b00001, 1'b0);
        step(5'b00000, 1'b0);
        step(5'b00000, 1'b0);

        // Random request traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) rnd_req = 5'($urandom_range(0, 31));
            step(rnd_req, ($urandom_range(0, 79) == 0));
        end
        step(5'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
